// File: rtl/fx_mac_array_if.sv
// Stream bundle for fx_mac_array: operand beats in, one saturated result per vector out.
`timescale 1ns/1ps
interface fx_mac_array_if #(
    parameter int width = 10,
    parameter int lanes = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [lanes*width-1:0] a;
    logic [lanes*width-1:0] b;
    logic                   out_valid;
    logic                   out_ready;
    logic [width-1:0]       sum;
    logic                   ovf;

    modport master (
        output in_valid, in_last, a, b, out_ready,
        input  in_ready, out_valid, sum, ovf
    );

    modport slave (
        input  in_valid, in_last, a, b, out_ready,
        output in_ready, out_valid, sum, ovf
    );
endinterface

// File: rtl/fx_mac_array.sv
// Multi-lane saturating fixed-point MAC: per-lane clamped products are summed per beat
// and accumulated over a vector; one saturated result per vector leaves on a valid/ready port.
`timescale 1ns/1ps
module fx_mac_array #(
    parameter int width       = 10,
    parameter int int_bits    = 2,
    parameter int lanes       = 4,
    parameter int pipe_stages = 2,
    parameter int rounding    = 1
) (
    input  logic          clk,
    input  logic          reset,
    fx_mac_array_if.slave io
);
    localparam int frac  = width - int_bits;
    localparam int sum_w = width + $clog2(lanes);
    localparam int acc_w = sum_w + 4;

    localparam logic signed [2*width-1:0] rnd_add =
        (rounding != 0 && frac > 0) ? ((2*width)'(1) << ((frac > 0) ? frac - 1 : 0)) : '0;
    localparam logic signed [2*width-1:0] p_max = {{(width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [2*width-1:0] p_min = {{(width+1){1'b1}}, {(width-1){1'b0}}};
    localparam logic signed [acc_w-1:0]   r_max = {{(acc_w-width+1){1'b0}}, {(width-1){1'b1}}};
    localparam logic signed [acc_w-1:0]   r_min = {{(acc_w-width+1){1'b1}}, {(width-1){1'b0}}};

    // Returns {sat, clamped product}; the product is rescaled to Q(int_bits.frac).
    function automatic logic [width:0] lane_mul(
        input logic signed [width-1:0] x,
        input logic signed [width-1:0] y
    );
        logic signed [2*width-1:0] prod;
        logic signed [2*width-1:0] shifted;
        prod    = (2*width)'(x) * (2*width)'(y);
        shifted = (prod + rnd_add) >>> frac;
        if (shifted > p_max)
            lane_mul = {1'b1, p_max[width-1:0]};
        else if (shifted < p_min)
            lane_mul = {1'b1, p_min[width-1:0]};
        else
            lane_mul = {1'b0, shifted[width-1:0]};
    endfunction

    typedef struct packed {
        logic                    valid;
        logic                    last;
        logic                    sat;
        logic signed [sum_w-1:0] lsum;
    } beat_t;

    logic                    en;
    logic                    out_valid_reg;
    logic [width-1:0]        sum_reg;
    logic                    ovf_reg;

    logic [width:0]          lane_res [lanes];
    logic [lanes-1:0]        lane_sat;
    logic signed [width-1:0] p_reg    [lanes];
    logic                    s1_valid_reg;
    logic                    s1_last_reg;
    logic                    s1_sat_reg;
    logic signed [sum_w-1:0] lsum;
    beat_t                   s2_in;
    beat_t                   acc_in;

    logic signed [acc_w-1:0] acc_reg;
    logic signed [acc_w-1:0] acc_base;
    logic signed [acc_w-1:0] acc_next;
    logic signed [acc_w:0]   acc_raw;
    logic                    acc_sat;
    logic [width-1:0]        res;
    logic                    res_sat;
    logic                    first_reg;
    logic                    sticky_reg;
    logic                    sticky_next;
    logic                    load;

    // A stalled output freezes the whole pipe, so nothing in flight is lost or repeated.
    assign en           = !(out_valid_reg && !io.out_ready);
    assign io.in_ready  = en;
    assign io.out_valid = out_valid_reg;
    assign io.sum       = sum_reg;
    assign io.ovf       = ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < lanes; gi++) begin : g_lane
            assign lane_res[gi] = lane_mul(io.a[gi*width +: width], io.b[gi*width +: width]);
            assign lane_sat[gi] = lane_res[gi][width];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_sat_reg   <= 1'b0;
            for (int i = 0; i < lanes; i++) p_reg[i] <= '0;
        end else if (en) begin
            s1_valid_reg <= io.in_valid;
            if (io.in_valid) begin
                s1_last_reg <= io.in_last;
                s1_sat_reg  <= |lane_sat;
                for (int i = 0; i < lanes; i++) p_reg[i] <= lane_res[i][width-1:0];
            end
        end
    end

    // Lane sum is wide enough for every lane at full scale, so it cannot overflow.
    always_comb begin
        lsum = '0;
        for (int i = 0; i < lanes; i++) lsum = lsum + sum_w'(p_reg[i]);
    end

    assign s2_in = {s1_valid_reg, s1_last_reg, s1_sat_reg, lsum};

    generate
        if (pipe_stages == 1) begin : g_no_dly
            assign acc_in = s2_in;
        end else begin : g_dly
            beat_t dly_reg [pipe_stages-1];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < pipe_stages-1; i++) dly_reg[i] <= '0;
                end else if (en) begin
                    dly_reg[0] <= s2_in;
                    for (int i = 1; i < pipe_stages-1; i++) dly_reg[i] <= dly_reg[i-1];
                end
            end
            assign acc_in = dly_reg[pipe_stages-2];
        end
    endgenerate

    always_comb begin
        acc_base = first_reg ? '0 : acc_reg;
        acc_raw  = (acc_w+1)'(acc_base) + (acc_w+1)'($signed(acc_in.lsum));
        acc_sat  = (acc_raw[acc_w] != acc_raw[acc_w-1]);
        if (!acc_sat)
            acc_next = acc_raw[acc_w-1:0];
        else if (acc_raw[acc_w])
            acc_next = {1'b1, {(acc_w-1){1'b0}}};
        else
            acc_next = {1'b0, {(acc_w-1){1'b1}}};

        res_sat = 1'b1;
        if (acc_next > r_max)
            res = r_max[width-1:0];
        else if (acc_next < r_min)
            res = r_min[width-1:0];
        else begin
            res     = acc_next[width-1:0];
            res_sat = 1'b0;
        end

        // The first beat of a vector starts the sticky flag afresh.
        sticky_next = (first_reg ? 1'b0 : sticky_reg) | acc_in.sat | acc_sat;
    end

    assign load = en && acc_in.valid && acc_in.last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg       <= '0;
            first_reg     <= 1'b1;
            sticky_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            if (en && acc_in.valid) begin
                acc_reg    <= acc_next;
                sticky_reg <= sticky_next;
                first_reg  <= acc_in.last;
            end
            if (load) begin
                sum_reg       <= res;
                ovf_reg       <= sticky_next | res_sat;
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && io.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fx_mac_array.sv
// Directed bench for fx_mac_array: a rounding=1 instance plus a rounding=0 twin on the same stimulus.
`timescale 1ns/1ps
module tb_fx_mac_array;
    localparam int width = 10;
    localparam int lanes = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    fx_mac_array_if #(.width(width), .lanes(lanes)) ifc ();
    fx_mac_array_if #(.width(width), .lanes(lanes)) ifc0 ();

    fx_mac_array #(.width(10), .int_bits(2), .lanes(4), .pipe_stages(2), .rounding(1)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (ifc)
    );

    fx_mac_array #(.width(10), .int_bits(2), .lanes(4), .pipe_stages(2), .rounding(0)) dut_r0 (
        .clk   (clk),
        .reset (reset),
        .io    (ifc0)
    );

    assign ifc0.in_valid  = ifc.in_valid;
    assign ifc0.in_last   = ifc.in_last;
    assign ifc0.a         = ifc.a;
    assign ifc0.b         = ifc.b;
    assign ifc0.out_ready = ifc.out_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [lanes*width-1:0] pack(input logic [9:0] v0, input logic [9:0] v1,
                                                     input logic [9:0] v2, input logic [9:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    // Called just after a clock edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [lanes*width-1:0] av, input logic [lanes*width-1:0] bv,
                        input logic last);
        int n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_last  = last;
        ifc.a        = av;
        ifc.b        = bv;
        while (ifc.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) check("send_ready", {31'b0, ifc.in_ready}, 32'd1);
        @(posedge clk); #1;
        $display("beat  a=%h b=%h last=%0d", av, bv, last);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [9:0] exp_sum, input logic exp_ovf,
                              input logic [9:0] exp_r0);
        int n = 0;
        ifc.out_ready = 1'b1;
        while (ifc.out_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        $display("result %s: sum=%h ovf=%0d r0_sum=%h", tag, ifc.sum, ifc.ovf, ifc0.sum);
        check({tag, "_valid"},  {31'b0, ifc.out_valid}, 32'd1);
        check({tag, "_sum"},    {22'b0, ifc.sum},       {22'b0, exp_sum});
        check({tag, "_ovf"},    {31'b0, ifc.ovf},       {31'b0, exp_ovf});
        check({tag, "_r0_sum"}, {22'b0, ifc0.sum},      {22'b0, exp_r0});
        check({tag, "_r0_ovf"}, {31'b0, ifc0.ovf},      {31'b0, exp_ovf});
        @(posedge clk); #1;
        check({tag, "_drain"},  {31'b0, ifc.out_valid}, 32'd0);
    endtask

    logic [lanes*width-1:0] a_one, b_q, b_half, b_16th;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_one  = pack(10'h100, 10'h100, 10'h100, 10'h100);
        b_q    = pack(10'h040, 10'h040, 10'h040, 10'h040);
        b_half = pack(10'h080, 10'h080, 10'h080, 10'h080);
        b_16th = pack(10'h010, 10'h010, 10'h010, 10'h010);

        reset         = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.in_last   = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("rst_sum",       {22'b0, ifc.sum},       32'd0);
        check("rst_ovf",       {31'b0, ifc.ovf},       32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready",  {31'b0, ifc.in_ready},  32'd1);

        // 1.0 * 0.25 on four lanes, with exact latency
        send(a_one, b_q, 1'b1);
        check("t1_lat1", {31'b0, ifc.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("t1_lat2", {31'b0, ifc.out_valid}, 32'd0);
        @(posedge clk); #1;
        check("t1_lat3", {31'b0, ifc.out_valid}, 32'd1);
        get_result("t1", 10'h100, 1'b0, 10'h100);

        // lane clamp both ways
        send(pack(10'h1FF, 10'h1FF, 10'h000, 10'h000), pack(10'h180, 10'h200, 10'h000, 10'h000), 1'b1);
        get_result("t2", 10'h3FF, 1'b1, 10'h3FF);

        // result clamp: lane sum 2.0
        send(a_one, b_half, 1'b1);
        get_result("t3", 10'h1FF, 1'b1, 10'h1FF);

        // rounding of half an LSB, positive and negative
        send(pack(10'h001, 10'h000, 10'h000, 10'h000), pack(10'h080, 10'h000, 10'h000, 10'h000), 1'b1);
        get_result("t4a", 10'h001, 1'b0, 10'h000);
        send(pack(10'h3FF, 10'h000, 10'h000, 10'h000), pack(10'h080, 10'h000, 10'h000, 10'h000), 1'b1);
        get_result("t4b", 10'h000, 1'b0, 10'h3FF);

        // 3-beat vector then 1-beat vector under backpressure
        ifc.out_ready = 1'b0;
        send(a_one, b_16th, 1'b0);
        send(a_one, b_16th, 1'b0);
        send(a_one, b_16th, 1'b1);
        send(a_one, b_q, 1'b1);
        check("t5_early_valid", {31'b0, ifc.out_valid}, 32'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_ready", {31'b0, ifc.in_ready},  32'd0);
            check("t5_hold_valid", {31'b0, ifc.out_valid}, 32'd1);
            check("t5_hold_sum",   {22'b0, ifc.sum},       32'h0C0);
            check("t5_hold_ovf",   {31'b0, ifc.ovf},       32'd0);
            @(posedge clk); #1;
        end
        $display("result t5a: sum=%h ovf=%0d (held)", ifc.sum, ifc.ovf);
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        get_result("t5b", 10'h100, 1'b0, 10'h100);

        // async reset after two beats have reached the accumulator
        send(a_one, b_q, 1'b0);
        send(a_one, b_q, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("t6_bubble_valid", {31'b0, ifc.out_valid}, 32'd0);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, ifc.out_valid}, 32'd0);
        check("t6_rst_sum",   {22'b0, ifc.sum},       32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        send(a_one, b_q, 1'b1);
        get_result("t6", 10'h100, 1'b0, 10'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fx_mac_array.md
Name: fx_mac_array

Overview:
- Parametrised successor to the team's saturating fixed-point multiplier.
- Multiplies `lanes` pairs of signed Q(int_bits.frac) operands per beat, saturates each product, sums the lanes and accumulates across a multi-beat vector until `in_last`.
- Emits one saturated width-bit result per vector through a valid/ready output.
- Sits between the weight/activation streamers and the neuron output register in the MLP datapath.

Parameters:
- width, 10: operand/result bit width, signed two's complement.
- int_bits, 2: integer bits including sign; frac = width-int_bits.
- lanes, 4: parallel multiplier lanes per beat, 1..16.
- pipe_stages, 2: multiplier pipeline depth, 1..3.
- rounding, 1: 0 = truncate (floor); 1 = round-half-up (add 2^(frac-1), then arithmetic shift).

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: input beat accepted when in_valid && in_ready.
- in_last, in, 1: final beat of the current vector.
- a, in, lanes*width: lane k at bits [k*width +: width].
- b, in, lanes*width: same packing as a.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts result.
- sum, out, width: saturated accumulated result.
- ovf, out, 1: any saturation occurred in this vector; qualified by out_valid.

Behaviour:
- Reset (async, asserted): out_valid=0, sum=0, ovf=0, accumulator=0, all pipeline valid bits=0, sticky flag=0. in_ready=1 once reset deasserts.
- Global advance enable: en = !(out_valid && !out_ready). in_ready = en.
- When en=0, every stage, the accumulator and the output hold. An in-flight beat is never dropped or duplicated.
- Lane product, per lane:
  - Full 2*width signed product.
  - Rounding per the `rounding` parameter, then right shift by frac.
  - Clamp to [-2^(width-1), 2^(width-1)-1].
  - Clamping sets that beat's sat bit.
- Lane sum: signed sum of clamped lane products, width+clog2(lanes) bits, no loss.
- Accumulator:
  - acc_w = width+clog2(lanes)+4 bits.
  - acc_next = acc (or 0 if this is the first beat after a last) + lane sum.
  - Clamps at acc_w bounds; clamping sets sat.
- Sticky flag = OR of sat over all beats of the vector; cleared when a new vector's first beat reaches the accumulator.
- Output:
  - When the last beat reaches the accumulator stage, sum <= clamp(acc_next to width) and ovf <= sticky | that clamp | that beat's sat.
  - out_valid <= 1 in the same cycle.
- Latency: last beat accepted at cycle t gives out_valid=1 at cycle t+pipe_stages+1, assuming no stall.
- Throughput: one beat per cycle. Back-to-back vectors are supported with no bubble; a single-beat vector is legal.
- Output handshake: out_valid falls after out_valid && out_ready unless a new result is loaded in the same cycle, in which case it stays 1 with new data.
- sum and ovf are stable while out_valid && !out_ready.
- Input data and in_last are ignored when in_valid=0. Bubbles do not disturb the accumulator.
- Reset mid-vector or mid-stall discards the partial accumulation and any pending result.

Test Plan:
- width=10, int_bits=2, lanes=4. Single beat, all a=0x100 (1.0), b=0x040 (0.25), last=1.
  - Expect sum=0x100, ovf=0, out_valid exactly 3 cycles after accept (pipe_stages=2).
- Lane saturation, single beat.
  - a lanes = 0x1FF, 0x1FF, 0x000, 0x000; b lanes = 0x180, 0x200, 0, 0.
  - Lane products clamp to 0x1FF and 0x200; expect sum=0x3FF (-1 LSB), ovf=1.
- Result saturation: all a=0x100, b=0x080, last=1.
  - Lane sum is 2.0; expect sum=0x1FF, ovf=1.
- Rounding: lane0 a=0x001, b=0x080, other lanes 0.
  - rounding=1: sum=0x001.
  - rebuild with rounding=0: sum=0x000.
  - Repeat with a=0x3FF (-1 LSB): expect 0x000 for rounding=1, 0x3FF for rounding=0. ovf=0 in all cases.
- Multi-beat with backpressure.
  - 3 beats, all a=0x100, b=0x010, last on beat 3; sum=0x0C0.
  - Immediately follow with a 1-beat vector giving 0x100.
  - Hold out_ready=0 for 5 cycles: expect in_ready=0, first result held stable, second result emitted after release.
  - Expect no corruption and ovf=0 on both.
- Async reset asserted between beats 2 and 3 of a vector.
  - Expect out_valid=0 and sum=0 immediately.
  - A following 1-beat vector of 0x100*0x040 per lane yields 0x100 with no residue from the aborted vector.
